// File: rtl/hssl_sync_monitor.sv
// Link-sync monitor for a multi-lane 8b/10b receiver: LOSS_OF_SYNC/RESYNC/SYNC_ACQUIRED FSM.
// Optional loss/error statistics counters are built when HSSL_SYNC_STATS_EN is defined.
module hssl_sync_monitor #(
    parameter int unsigned NUM_LANES         = 4,
    parameter int unsigned NUM_CLKC_FOR_SYNC = 4,
    parameter int unsigned NUM_VLD_PER_INV   = 4,
    parameter int unsigned NUM_INV_FOR_LOSS  = 8,
    parameter int unsigned CNT_BITS          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_commadet_in,
    input  logic [NUM_LANES-1:0] rx_disperr_in,
    input  logic [NUM_LANES-1:0] rx_encerr_in,
    input  logic                 rx_vld_in,
    input  logic                 realign_in,
    input  logic                 force_resync_in,
    input  logic                 clr_cnt_in,
    output logic [1:0]           loss_of_sync_state_out,
    output logic                 sync_acquired_out,
    output logic                 loss_event_out,
    output logic [CNT_BITS-1:0]  loss_cnt_out,
    output logic [CNT_BITS-1:0]  err_cnt_out
);

    localparam int unsigned ResyncW = $clog2(NUM_CLKC_FOR_SYNC + 1);
    // inv_cnt never exceeds NUM_INV_FOR_LOSS-1 before one more invalid flit is added.
    localparam int unsigned InvW    = $clog2(NUM_INV_FOR_LOSS + NUM_VLD_PER_INV);

    typedef enum logic [1:0] {
        StSyncAcquired = 2'b00,
        StResync       = 2'b01,
        StLossOfSync   = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [ResyncW-1:0] resync_cnt_q, resync_cnt_d;
    logic [InvW-1:0]    inv_cnt_q, inv_cnt_d;
    logic               loss_event_q, loss_event_d;
    logic               invalid_data;

    assign invalid_data = (|rx_disperr_in) | (|rx_encerr_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLossOfSync;
            resync_cnt_q <= '0;
            inv_cnt_q    <= '0;
            loss_event_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resync_cnt_q <= resync_cnt_d;
            inv_cnt_q    <= inv_cnt_d;
            loss_event_q <= loss_event_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (force_resync_in) begin
            state_d = StLossOfSync;
        end else begin
            case (state_q)
                StLossOfSync: begin
                    if (rx_commadet_in) state_d = StResync;
                end
                StResync: begin
                    if (invalid_data) begin
                        state_d = StLossOfSync;
                    end else if (resync_cnt_q == ResyncW'(NUM_CLKC_FOR_SYNC - 1)) begin
                        state_d = StSyncAcquired;
                    end
                end
                StSyncAcquired: begin
                    if (realign_in) begin
                        state_d = StResync;
                    end else if (inv_cnt_q >= InvW'(NUM_INV_FOR_LOSS)) begin
                        state_d = StLossOfSync;
                    end
                end
                default: state_d = StLossOfSync;
            endcase
        end
    end

    // Counters only run while the FSM stays put; any transition lands them at zero.
    always_comb begin
        resync_cnt_d = '0;
        inv_cnt_d    = '0;
        if (state_q == StResync && state_d == StResync) begin
            resync_cnt_d = resync_cnt_q + ResyncW'(1);
        end
        if (state_q == StSyncAcquired && state_d == StSyncAcquired) begin
            if (invalid_data) begin
                inv_cnt_d = inv_cnt_q + InvW'(NUM_VLD_PER_INV);
            end else if (rx_vld_in && inv_cnt_q != '0) begin
                inv_cnt_d = inv_cnt_q - InvW'(1);
            end else begin
                inv_cnt_d = inv_cnt_q;
            end
        end
        loss_event_d = (state_d == StLossOfSync) && (state_q != StLossOfSync);
    end

    always_comb begin
        loss_of_sync_state_out = state_q;
        sync_acquired_out      = (state_q == StSyncAcquired);
        loss_event_out         = loss_event_q;
    end

`ifdef HSSL_SYNC_STATS_EN
    logic [CNT_BITS-1:0] loss_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_cnt_in) begin
            loss_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (loss_event_d && loss_cnt_q != '1) loss_cnt_q <= loss_cnt_q + CNT_BITS'(1);
            if (invalid_data && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_BITS'(1);
        end
    end

    assign loss_cnt_out = loss_cnt_q;
    assign err_cnt_out  = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt_in;
    assign loss_cnt_out   = '0;
    assign err_cnt_out    = '0;
`endif

endmodule

// File: doc/hssl_sync_monitor.md
HSSL_SYNC_MONITOR -- requirements
Module: hssl_sync_monitor

Interface
REQ-001 The block SHALL have parameters: NUM_LANES, default 4, bytes per received word; NUM_CLKC_FOR_SYNC, default 4, clean cycles in RESYNC before sync; NUM_VLD_PER_INV, default 4, valid flits that cancel one invalid flit; NUM_INV_FOR_LOSS, default 8, uncancelled-invalid threshold; CNT_BITS, default 16, statistics counter width.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock;
- reset  in  1  synchronous, active-high reset;
- rx_commadet_in  in  1  comma detected;
- rx_disperr_in  in  NUM_LANES  per-byte disparity error;
- rx_encerr_in  in  NUM_LANES  per-byte 8b/10b code error;
- rx_vld_in  in  1  valid flit received;
- realign_in  in  1  transceiver comma-realignment pulse;
- force_resync_in  in  1  software-forced loss of sync;
- clr_cnt_in  in  1  clear statistics;
- loss_of_sync_state_out  out  2  FSM state;
- sync_acquired_out  out  1  high iff state is SYNC_ACQUIRED;
- loss_event_out  out  1  one-cycle pulse on every entry to LOSS_OF_SYNC;
- loss_cnt_out  out  CNT_BITS  loss-event count;
- err_cnt_out  out  CNT_BITS  invalid-data cycle count.

Function
REQ-003 invalid_data SHALL be the OR of all bits of rx_disperr_in and rx_encerr_in; it is combinational and uses the same-cycle inputs.
REQ-004 The state encodings SHALL be LOSS_OF_SYNC = 2'b10, RESYNC = 2'b01 and SYNC_ACQUIRED = 2'b00; loss_of_sync_state_out SHALL be the state register, with no added latency.
REQ-005 In LOSS_OF_SYNC, rx_commadet_in = 1 SHALL move the FSM to RESYNC on the next edge.
REQ-006 In RESYNC:
- invalid_data SHALL move the FSM to LOSS_OF_SYNC;
- otherwise resync_cnt SHALL increment;
- on the cycle where resync_cnt == NUM_CLKC_FOR_SYNC-1 without invalid_data, the FSM SHALL move to SYNC_ACQUIRED, so RESYNC lasts exactly NUM_CLKC_FOR_SYNC clean cycles.
REQ-007 resync_cnt SHALL be 0 in every state other than RESYNC, and SHALL be $clog2(NUM_CLKC_FOR_SYNC+1) bits wide.
REQ-008 In SYNC_ACQUIRED, inv_cnt SHALL update as follows:
- invalid_data: add NUM_VLD_PER_INV;
- else rx_vld_in with inv_cnt != 0: subtract 1;
- invalid_data with rx_vld_in in the same cycle: invalid_data wins.
REQ-009 inv_cnt SHALL be 0 outside SYNC_ACQUIRED, and SHALL be wide enough to hold NUM_INV_FOR_LOSS+NUM_VLD_PER_INV-1 without wrap.
REQ-010 In SYNC_ACQUIRED, a registered inv_cnt >= NUM_INV_FOR_LOSS SHALL move the FSM to LOSS_OF_SYNC on the next edge.
REQ-011 In SYNC_ACQUIRED, realign_in = 1 SHALL move the FSM to RESYNC and clear resync_cnt; this takes priority over the REQ-010 transition.
REQ-012 force_resync_in = 1 SHALL move the FSM to LOSS_OF_SYNC from any state, with priority over all other transitions; while it is held, the FSM SHALL stay in LOSS_OF_SYNC.
REQ-013 An illegal state (2'b11) SHALL move the FSM to LOSS_OF_SYNC on the next edge.
REQ-014 loss_event_out SHALL be registered, asserted for one cycle on the first cycle the state equals LOSS_OF_SYNC after any other state; it SHALL not assert when leaving reset, or while already in LOSS_OF_SYNC under force_resync_in.

Reset
REQ-015 While reset is high at a clk edge, the block SHALL set: state = LOSS_OF_SYNC; resync_cnt, inv_cnt, loss_cnt_out and err_cnt_out = 0; sync_acquired_out = 0; loss_event_out = 0.
REQ-016 Reset asserted mid-operation in any state SHALL take effect on the next edge, with priority over force_resync_in and clr_cnt_in.

Configuration
REQ-017 With the macro HSSL_SYNC_STATS_EN defined:
- loss_cnt_out SHALL increment once per loss_event_out pulse;
- err_cnt_out SHALL increment on every cycle with invalid_data, in any state;
- both SHALL saturate at all-ones;
- clr_cnt_in SHALL zero both on the next edge, and clear wins over a same-cycle increment.
REQ-018 Without HSSL_SYNC_STATS_EN, loss_cnt_out and err_cnt_out SHALL be constant 0, clr_cnt_in SHALL be ignored, and no counter registers SHALL be inferred.

Verification
REQ-019 Reset release, then rx_commadet_in=1 for one cycle, then 4 clean cycles -> state 10 -> 01, then 00 exactly 4 cycles after entering 01; sync_acquired_out=1.
REQ-020 In RESYNC, rx_encerr_in=4'b0010 on the 3rd cycle -> state 10 next edge; loss_event_out pulses once; err_cnt_out=1 (macro on).
REQ-021 In SYNC, 2 invalid cycles -> inv_cnt=8, state 10 one edge later; with 1 invalid cycle then 4 rx_vld_in cycles, inv_cnt returns to 0 and the state stays 00.
REQ-022 In SYNC, realign_in and force_resync_in asserted in the same cycle -> state 10 (force wins); realign_in alone -> state 01, and 00 again after 4 clean cycles.
REQ-023 Macro on: CNT_BITS=4, 20 invalid cycles -> err_cnt_out saturates at 15; clr_cnt_in together with invalid_data -> 0. Macro off: both counts stay 0 throughout.
